round_health_controller: RTL
============================

Name: round_health_controller

Overview:
- Owns both players' current health values and applies damage from the left and right attack requesters through a round-robin arbiter, one hit per cycle.
- Sequences each round: idle, fight, drain (waits for the animated status-bar health to settle), KO hold, then next round or match end.
- Drives curr_health_l/curr_health_r into the status bar and reads back its animated final_health_l/final_health_r.

Parameters:
MAX_HEALTH, 9'd400, health loaded at reset and at every round start (1..511)
KO_HOLD_CYCLES, 32'd50_000_000, clk cycles the KO state is held before advancing (>=1)
ROUNDS_TO_WIN, 2, round wins that end the match (1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse: begin round / restart match
hit_l_req  in  1  left player landed a hit on right player; level, held until ack
hit_l_dmg  in  8  damage for hit_l_req, stable while req high
hit_r_req  in  1  right player landed a hit on left player
hit_r_dmg  in  8  damage for hit_r_req
hit_l_ack  out  1  one-cycle grant pulse for hit_l_req
hit_r_ack  out  1  one-cycle grant pulse for hit_r_req
final_health_l  in  9  animated left health from status bar
final_health_r  in  9  animated right health from status bar
curr_health_l  out  9  left player health
curr_health_r  out  9  right player health
ko  out  1  high in KO_HOLD and MATCH_END
winner  out  2  01 left won round, 10 right won, 00 none
wins_l  out  2  left round wins
wins_r  out  2  right round wins
match_over  out  1  high in MATCH_END
state  out  3  current FSM state encoding

Behaviour:
- Reset (async, any state): curr_health_l/r=MAX_HEALTH, state=IDLE, acks=0, ko=0, winner=00, wins_l/r=0, match_over=0, hold counter=0, RR pointer=left.
- States: IDLE=0, FIGHT=1, DRAIN=2, KO_HOLD=3, MATCH_END=4. All outputs are registered.
- IDLE: start -> FIGHT next edge. Requests are ignored and no acks are issued.
- FIGHT arbitration on each edge:
  - Eligible requester: req high and its ack not high this cycle, which prevents double application.
  - One eligible: grant it.
  - Both eligible: grant the RR pointer side. The pointer flips to the other side after every grant.
- Grant effect at the same edge:
  - The target health updates to (health > dmg) ? health - dmg : 0.
  - The matching ack is high for exactly the following cycle.
  - hit_l_req damages curr_health_r. hit_r_req damages curr_health_l.
  - dmg=0 is still granted and acked, with health unchanged.
- FIGHT -> DRAIN at the edge after a grant leaves either health at 0. Both cannot reach 0 on the same edge, since there is one grant per cycle.
- DRAIN:
  - No grants, no acks; pending requests stay unserved.
  - Each cycle compare final_health_l==curr_health_l and final_health_r==curr_health_r.
  - When both match: next edge -> KO_HOLD, ko=1, winner = side with nonzero health, that side's wins+1, hold counter cleared.
- KO_HOLD:
  - Counter increments each cycle. At count KO_HOLD_CYCLES-1 the next edge leaves the state.
  - If the winner's wins == ROUNDS_TO_WIN: -> MATCH_END, match_over=1, ko and winner retained.
  - Else: -> IDLE, healths reloaded to MAX_HEALTH, ko=0, winner=00.
- MATCH_END: holds until start. On start, next edge -> FIGHT with healths=MAX_HEALTH, wins=0, ko=0, winner=00, match_over=0, RR pointer=left.
- start in FIGHT/DRAIN/KO_HOLD is ignored. Hits in IDLE/KO_HOLD/MATCH_END are ignored, with no ack.
- Wins counters saturate at 3.
- Reset asserted mid-round or mid-hold returns to the reset values immediately. Any in-flight ack is dropped.

Test Plan:
- Reset, start, hit_l_req with dmg=50 held -> hit_l_ack pulses once one cycle after grant; curr_health_r=350; curr_health_l=400; no second grant while req stays high during the ack cycle.
- Both reqs high (dmg 10/20) for two grants from fresh reset -> left granted first (curr_health_r=390), then right (curr_health_l=380); acks in consecutive cycles.
- curr_health_r=30, hit_l_dmg=100 -> curr_health_r=0 (clamped), state=DRAIN; further reqs not acked; final_health_r held at 30 keeps DRAIN; set it to 0 -> KO_HOLD, ko=1, winner=01, wins_l=1.
- KO_HOLD_CYCLES=4, wins_l=1 after round -> IDLE after exactly 4 hold cycles with healths=400, ko=0; second left round win -> MATCH_END, match_over=1, ko=1; start -> FIGHT, wins=0.
- Assert reset during KO_HOLD and while an ack is high -> immediately IDLE, ack=0, healths=400, wins=0; start ignored in FIGHT leaves state=1.

Source files
------------

// File: rtl/round_health_controller.sv
// Round controller for a two-player fight: arbitrates hits onto both health
// values and sequences fight, status-bar drain, KO hold and match end.
module round_health_controller #(
  parameter logic [8:0]  MAX_HEALTH     = 9'd400,
  parameter logic [31:0] KO_HOLD_CYCLES = 32'd50_000_000,
  parameter int          ROUNDS_TO_WIN  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit_l_req,
  input  logic [7:0] hit_l_dmg,
  input  logic       hit_r_req,
  input  logic [7:0] hit_r_dmg,
  output logic       hit_l_ack,
  output logic       hit_r_ack,
  input  logic [8:0] final_health_l,
  input  logic [8:0] final_health_r,
  output logic [8:0] curr_health_l,
  output logic [8:0] curr_health_r,
  output logic       ko,
  output logic [1:0] winner,
  output logic [1:0] wins_l,
  output logic [1:0] wins_r,
  output logic       match_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIGHT     = 3'd1,
    DRAIN     = 3'd2,
    KO_HOLD   = 3'd3,
    MATCH_END = 3'd4
  } state_t;

  localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);

  function automatic logic [8:0] apply_dmg(input logic [8:0] health, input logic [7:0] dmg);
    logic [8:0] dmg_ext;
    dmg_ext = {1'b0, dmg};
    return (health > dmg_ext) ? health - dmg_ext : 9'd0;
  endfunction

  function automatic logic [1:0] inc_sat(input logic [1:0] w);
    return (w == 2'd3) ? w : w + 2'd1;
  endfunction

  state_t      state_q;
  logic        rr_ptr;     // 0: left wins a tie, 1: right wins a tie
  logic [31:0] hold_cnt;

  logic       elig_l, elig_r, grant_l, grant_r;
  logic [8:0] new_health_l, new_health_r;
  logic       hold_done, win_reached, bars_settled;

  // A requester whose ack is currently high has already been served.
  assign elig_l  = hit_l_req & ~hit_l_ack;
  assign elig_r  = hit_r_req & ~hit_r_ack;
  assign grant_l = elig_l & (~elig_r | ~rr_ptr);
  assign grant_r = elig_r & (~elig_l | rr_ptr);

  assign new_health_r = apply_dmg(curr_health_r, hit_l_dmg);
  assign new_health_l = apply_dmg(curr_health_l, hit_r_dmg);

  assign bars_settled = (final_health_l == curr_health_l) && (final_health_r == curr_health_r);
  assign hold_done    = (hold_cnt == KO_HOLD_CYCLES - 32'd1);
  assign win_reached  = (winner == 2'b01) ? (wins_l == WIN_TARGET) : (wins_r == WIN_TARGET);

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      curr_health_l <= MAX_HEALTH;
      curr_health_r <= MAX_HEALTH;
      hit_l_ack     <= 1'b0;
      hit_r_ack     <= 1'b0;
      ko            <= 1'b0;
      winner        <= 2'b00;
      wins_l        <= 2'd0;
      wins_r        <= 2'd0;
      match_over    <= 1'b0;
      hold_cnt      <= 32'd0;
      rr_ptr        <= 1'b0;
    end else begin
      hit_l_ack <= 1'b0;
      hit_r_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= FIGHT;
        end
        FIGHT: begin
          if (grant_l) begin
            curr_health_r <= new_health_r;
            hit_l_ack     <= 1'b1;
            rr_ptr        <= 1'b1;
            if (new_health_r == 9'd0) state_q <= DRAIN;
          end else if (grant_r) begin
            curr_health_l <= new_health_l;
            hit_r_ack     <= 1'b1;
            rr_ptr        <= 1'b0;
            if (new_health_l == 9'd0) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bars_settled) begin
            state_q  <= KO_HOLD;
            ko       <= 1'b1;
            hold_cnt <= 32'd0;
            if (curr_health_l != 9'd0) begin
              winner <= 2'b01;
              wins_l <= inc_sat(wins_l);
            end else begin
              winner <= 2'b10;
              wins_r <= inc_sat(wins_r);
            end
          end
        end
        KO_HOLD: begin
          hold_cnt <= hold_cnt + 32'd1;
          if (hold_done) begin
            if (win_reached) begin
              state_q    <= MATCH_END;
              match_over <= 1'b1;
            end else begin
              state_q       <= IDLE;
              curr_health_l <= MAX_HEALTH;
              curr_health_r <= MAX_HEALTH;
              ko            <= 1'b0;
              winner        <= 2'b00;
            end
          end
        end
        MATCH_END: begin
          if (start) begin
            state_q       <= FIGHT;
            curr_health_l <= MAX_HEALTH;
            curr_health_r <= MAX_HEALTH;
            wins_l        <= 2'd0;
            wins_r        <= 2'd0;
            ko            <= 1'b0;
            winner        <= 2'b00;
            match_over    <= 1'b0;
            rr_ptr        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
